conv_line_buffer: RTL and testbench

CONV_LINE_BUFFER -- requirements
Module: conv_line_buffer

---
 rtl/conv_pkg.sv | 12 +
 rtl/conv_line_buffer_line_ram.sv | 19 +
 rtl/conv_line_buffer.sv | 67 ++++++
 tb/tb_conv_line_buffer.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared defaults, state encoding and counter-width helpers for the line buffer.
package conv_pkg;
  localparam int PIXEL_WIDTH_DEF = 8;
  localparam int IMG_WIDTH_DEF = 640;
  localparam int IMG_HEIGHT_DEF = 480;
  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;
  function automatic int cnt_w(input int n);
    return n < 2 ? 1 : $clog2(n);
  endfunction
  localparam int COL_W_DEF = cnt_w(IMG_WIDTH_DEF);
  localparam int ROW_W_DEF = cnt_w(IMG_HEIGHT_DEF);
endpackage

// File: rtl/conv_line_buffer_line_ram.sv
// line_ram: one image line of pixels, combinational read, synchronous write; contents are never reset.
module line_ram
  import conv_pkg::*;
#(
  parameter int DEPTH = IMG_WIDTH_DEF,
  parameter int WIDTH = PIXEL_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [cnt_w(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]        wdata,
  output logic [WIDTH-1:0]        rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  assign rdata = mem[addr];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end
endmodule

// File: rtl/conv_line_buffer.sv
// conv_line_buffer: raster pixels in, registered vertical column triples out for a 3x3 convolver.
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int PIXEL_WIDTH = PIXEL_WIDTH_DEF,
  parameter int IMG_WIDTH = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pix_valid,
  input  logic                   sof,
  input  logic [PIXEL_WIDTH-1:0] pix_in,
  output logic [PIXEL_WIDTH-1:0] pix_top,
  output logic [PIXEL_WIDTH-1:0] pix_mid,
  output logic [PIXEL_WIDTH-1:0] pix_bot,
  output logic                   shift_en,
  output logic                   win_valid,
  output logic                   sof_err
);
  localparam int CW = cnt_w(IMG_WIDTH);
  localparam int RW = cnt_w(IMG_HEIGHT);
  state_t state;
  logic [CW-1:0] col, c;
  logic [RW-1:0] row, r;
  logic start, accept, last_col, last_row;
  logic [PIXEL_WIDTH-1:0] l1_rd, l2_rd;
  // sof always re-anchors the current pixel at (0,0), whatever the counters say
  assign start = pix_valid && sof;
  assign accept = start || (pix_valid && state != IDLE);
  assign c = start ? '0 : col;
  assign r = start ? '0 : row;
  assign last_col = c == CW'(IMG_WIDTH - 1);
  assign last_row = r == RW'(IMG_HEIGHT - 1);
  line_ram #(.DEPTH(IMG_WIDTH), .WIDTH(PIXEL_WIDTH)) u_line1 (
    .clk(clk), .we(accept), .addr(c), .wdata(pix_in), .rdata(l1_rd)
  );
  line_ram #(.DEPTH(IMG_WIDTH), .WIDTH(PIXEL_WIDTH)) u_line2 (
    .clk(clk), .we(accept), .addr(c), .wdata(l1_rd), .rdata(l2_rd)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      col <= '0;
      row <= '0;
      pix_top <= '0;
      pix_mid <= '0;
      pix_bot <= '0;
      shift_en <= 1'b0;
      win_valid <= 1'b0;
      sof_err <= 1'b0;
    end else begin
      shift_en <= accept;
      win_valid <= accept && r >= RW'(2) && c >= CW'(2);
      sof_err <= start && state != IDLE;
      if (accept) begin
        pix_top <= l2_rd;
        pix_mid <= l1_rd;
        pix_bot <= pix_in;
        col <= last_col ? '0 : c + 1'b1;
        row <= last_col ? (last_row ? '0 : r + 1'b1) : r;
        state <= (last_col && last_row) ? IDLE :
                 (r >= RW'(2) || (last_col && r == RW'(1))) ? RUN : PRIME;
      end
    end
  end
endmodule

// File: tb/tb_conv_line_buffer.sv
// tb_conv_line_buffer: directed frames on a 4x4 image (pixel = 16*row+col) with a queue scoreboard.
module tb_conv_line_buffer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pix_valid = 1'b0;
  logic sof = 1'b0;
  logic [7:0] pix_in = '0;
  logic [7:0] pix_top, pix_mid, pix_bot;
  logic shift_en, win_valid, sof_err;
  typedef struct {
    logic [7:0] top, mid, bot;
    logic known, win;
  } exp_t;
  exp_t q[$];
  int checks = 0, failures = 0;
  int win_cnt = 0, sof_err_cnt = 0, dbl_cnt = 0, se_cnt = 0;
  logic prev_se = 1'b0;

  conv_line_buffer #(.PIXEL_WIDTH(8), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut (
    .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .sof(sof), .pix_in(pix_in),
    .pix_top(pix_top), .pix_mid(pix_mid), .pix_bot(pix_bot),
    .shift_en(shift_en), .win_valid(win_valid), .sof_err(sof_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // monitor: pops one expected triple per shift_en
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (sof_err) sof_err_cnt++;
        if (win_valid) win_cnt++;
        if (shift_en) se_cnt++;
        if (shift_en && prev_se) dbl_cnt++;
        prev_se = shift_en;
        if (shift_en) begin
          if (q.size() == 0) chk("unexpected_shift_en", 1, 0);
          else begin
            e = q.pop_front();
            chk("pix_bot", pix_bot, e.bot);
            chk("win_valid", win_valid, e.win);
            if (e.known) begin
              chk("pix_top", pix_top, e.top);
              chk("pix_mid", pix_mid, e.mid);
            end
          end
        end else if (win_valid) chk("win_without_shift", 1, 0);
      end else prev_se = 1'b0;
    end
  end

  task automatic send(input int r, input int c, input bit s, input bit push, input int gap);
    pix_valid = 1'b1;
    sof = s;
    pix_in = 8'(16 * r + c);
    if (push)
      q.push_back('{top: 8'(16 * (r - 2) + c), mid: 8'(16 * (r - 1) + c),
                    bot: 8'(16 * r + c), known: r >= 2, win: r >= 2 && c >= 2});
    @(negedge clk);
    if (gap > 0) begin
      pix_valid = 1'b0;
      sof = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    pix_valid = 1'b0;
    sof = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic frame(input int gap);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) send(r, c, r == 0 && c == 0, 1'b1, gap);
  endtask

  initial begin
    #3;
    chk("reset_top", pix_top, 0);
    chk("reset_shift_en", shift_en, 0);
    chk("reset_win_valid", win_valid, 0);
    chk("reset_sof_err", sof_err, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    win_cnt = 0;
    frame(0);
    idle(2);
    chk("t1_win_count", win_cnt, 4);
    win_cnt = 0;
    dbl_cnt = 0;
    frame(1);
    idle(2);
    chk("t2_win_count", win_cnt, 4);
    chk("t2_consecutive_shift", dbl_cnt, 0);
    for (int c = 1; c < 4; c++) send(3, c, 1'b0, 1'b0, 0);
    win_cnt = 0;
    frame(0);
    idle(2);
    chk("t3_win_count", win_cnt, 4);
    win_cnt = 0;
    sof_err_cnt = 0;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++) send(r, c, r == 0 && c == 0, 1'b1, 0);
    send(2, 0, 1'b0, 1'b1, 0);
    frame(0);
    idle(2);
    chk("t4_sof_err_count", sof_err_cnt, 1);
    chk("t4_win_count", win_cnt, 2 + 4 - 2);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++) send(r, c, r == 0 && c == 0, 1'b1, 0);
    idle(1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_top", pix_top, 0);
    chk("async_rst_mid", pix_mid, 0);
    chk("async_rst_bot", pix_bot, 0);
    chk("async_rst_win", win_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    se_cnt = 0;
    for (int c = 0; c < 4; c++) send(3, c, 1'b0, 1'b0, 0);
    idle(2);
    chk("t5_shift_after_reset", se_cnt, 0);
    chk("t5_bot_held", pix_bot, 0);
    win_cnt = 0;
    frame(0);
    frame(0);
    idle(2);
    chk("t6_win_count", win_cnt, 8);
    chk("scoreboard_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
